// File: rtl/mcu_control_fsm.sv
// Multi-cycle main control FSM: fetch/decode/load-store sequencing with
// memory handshakes, retire counter, watchdog and sticky illegal/timeout trap.
module mcu_control_fsm #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 MCU_CLOCK_50,
  input  logic                 MCU_RESET_InHigh,
  input  logic [6:0]           MCU_Opcode_InBUS,
  output logic                 MCU_Imem_Req_Valid,
  input  logic                 MCU_Imem_Req_Ready,
  input  logic                 MCU_Imem_Resp_Valid,
  output logic                 MCU_Dmem_Req_Valid,
  input  logic                 MCU_Dmem_Req_Ready,
  input  logic                 MCU_Dmem_Resp_Valid,
  output logic [2:0]           MCU_State_OutBUS,
  output logic                 MCU_Ir_Write,
  output logic                 MCU_Pc_Write,
  output logic                 MCU_Load_Wb,
  output logic                 MCU_Trap,
  output logic [1:0]           MCU_Trap_Cause_OutBUS,
  output logic [CNT_WIDTH-1:0] MCU_Retired_OutBUS
);

  typedef enum logic [2:0] {
    S_RESET      = 3'b000,
    S_FETCH_REQ  = 3'b001,
    S_FETCH_WAIT = 3'b010,
    S_DECODE     = 3'b011,
    S_MEM_REQ    = 3'b100,
    S_MEM_WAIT   = 3'b101,
    S_TRAP       = 3'b110,
    S_BAD        = 3'b111
  } state_e;

  localparam int WD_W = 16;
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] C_ILLEGAL = 2'b01;
  localparam logic [1:0] C_IMEM    = 2'b10;
  localparam logic [1:0] C_DMEM    = 2'b11;

  state_e               state_q, state_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic [WD_W-1:0]      wd_q, wd_d;

  logic legal;
  logic is_mem;
  logic expire;

  always_comb begin
    legal = 1'b0;
    case (MCU_Opcode_InBUS)
      7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_mem = ~MCU_Opcode_InBUS[6] &
                  (MCU_Opcode_InBUS[4:0] == 5'b00011);

  // wd_q counts cycles already spent in the current state
  assign expire = WD_EN && (wd_q == WD_LAST);

  always_comb begin
    state_d            = state_q;
    cause_d            = cause_q;
    ret_d              = ret_q;
    wd_d               = wd_q + 1'b1;
    MCU_Imem_Req_Valid = 1'b0;
    MCU_Dmem_Req_Valid = 1'b0;
    MCU_Ir_Write       = 1'b0;
    MCU_Pc_Write       = 1'b0;
    MCU_Load_Wb        = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        MCU_Imem_Req_Valid = 1'b1;
        if (MCU_Imem_Req_Ready) begin
          state_d = S_FETCH_WAIT;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_IMEM;
        end
      end
      S_FETCH_WAIT: begin
        if (MCU_Imem_Resp_Valid) begin
          MCU_Ir_Write = 1'b1;
          state_d      = S_DECODE;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_IMEM;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end else if (is_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          MCU_Pc_Write = 1'b1;
          state_d      = S_FETCH_REQ;
        end
      end
      S_MEM_REQ: begin
        MCU_Dmem_Req_Valid = 1'b1;
        if (MCU_Dmem_Req_Ready) begin
          state_d = S_MEM_WAIT;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_DMEM;
        end
      end
      S_MEM_WAIT: begin
        if (MCU_Dmem_Resp_Valid) begin
          MCU_Pc_Write = 1'b1;
          MCU_Load_Wb  = ~MCU_Opcode_InBUS[5];
          state_d      = S_FETCH_REQ;
        end else if (expire) begin
          state_d = S_TRAP;
          cause_d = C_DMEM;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RESET;
    endcase
    if (MCU_Pc_Write) ret_d = ret_q + 1'b1;
    if (state_d != state_q) wd_d = '0;
  end

  always_ff @(posedge MCU_CLOCK_50) begin
    if (MCU_RESET_InHigh) begin
      state_q <= S_RESET;
      cause_q <= 2'b00;
      ret_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
      wd_q    <= wd_d;
    end
  end

  assign MCU_State_OutBUS      = state_q;
  assign MCU_Trap              = (state_q == S_TRAP);
  assign MCU_Trap_Cause_OutBUS = cause_q;
  assign MCU_Retired_OutBUS    = ret_q;

endmodule

// File: tb/tb_mcu_control_fsm.sv
// Directed bench for mcu_control_fsm: per-cycle vector table plus
// hand sequences for reset, watchdog and counter wrap.
module tb_mcu_control_fsm;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic       irr, irv, drr, drv;
  logic       ireq, dreq, irw, pcw, lwb, trap;
  logic [2:0] st;
  logic [1:0] cause;
  logic [3:0] ret;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcu_control_fsm #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(4)) dut (
    .MCU_CLOCK_50         (clk),
    .MCU_RESET_InHigh     (rst),
    .MCU_Opcode_InBUS     (opc),
    .MCU_Imem_Req_Valid   (ireq),
    .MCU_Imem_Req_Ready   (irr),
    .MCU_Imem_Resp_Valid  (irv),
    .MCU_Dmem_Req_Valid   (dreq),
    .MCU_Dmem_Req_Ready   (drr),
    .MCU_Dmem_Resp_Valid  (drv),
    .MCU_State_OutBUS     (st),
    .MCU_Ir_Write         (irw),
    .MCU_Pc_Write         (pcw),
    .MCU_Load_Wb          (lwb),
    .MCU_Trap             (trap),
    .MCU_Trap_Cause_OutBUS(cause),
    .MCU_Retired_OutBUS   (ret)
  );

  typedef struct {
    logic       r;
    logic [6:0] o;
    logic [3:0] hs;   // {irr, irv, drr, drv}
    logic [2:0] st;
    logic [4:0] stb;  // {ireq, dreq, ir, pc, lwb}
    logic       tr;
    logic [1:0] cs;
    logic [3:0] rt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [6:0] o, input logic [3:0] hs,
    input logic [2:0] s, input logic [4:0] stb,
    input logic tr, input logic [1:0] cs, input logic [3:0] rt);
    vec_t v;
    v.r = r; v.o = o; v.hs = hs; v.st = s;
    v.stb = stb; v.tr = tr; v.cs = cs; v.rt = rt;
    return v;
  endfunction

  task automatic chk(input string nm, input string tag,
                     input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // drive at negedge, sample combinational outputs before the next posedge
  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.r;
    opc = v.o;
    {irr, irv, drr, drv} = v.hs;
    #1;
    chk("state", tag, 8'(st), 8'(v.st));
    chk("imem_req", tag, 8'(ireq), 8'(v.stb[4]));
    chk("dmem_req", tag, 8'(dreq), 8'(v.stb[3]));
    chk("ir_write", tag, 8'(irw), 8'(v.stb[2]));
    chk("pc_write", tag, 8'(pcw), 8'(v.stb[1]));
    chk("load_wb", tag, 8'(lwb), 8'(v.stb[0]));
    chk("trap", tag, 8'(trap), 8'(v.tr));
    chk("cause", tag, 8'(cause), 8'(v.cs));
    chk("retired", tag, 8'(ret), 8'(v.rt));
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    {irr, irv, drr, drv} = 4'b0000;
    opc = OP_ADDI;
  endtask

  initial begin
    rst = 1'b1;
    opc = OP_ADDI;
    {irr, irv, drr, drv} = 4'b0000;
    hold_reset();
    hold_reset();

    // two ADDI, zero-wait LW, delayed SW, then illegal opcode
    tbl.push_back(mk(0, OP_ADDI, 4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, OP_ADDI, 4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, OP_ADDI, 4'b0000, 3'd3, 5'b00010, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd1));
    tbl.push_back(mk(0, OP_ADDI, 4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd1));
    tbl.push_back(mk(0, OP_ADDI, 4'b0000, 3'd3, 5'b00010, 0, 2'b00, 4'd1));
    tbl.push_back(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd2));
    tbl.push_back(mk(0, OP_ADDI, 4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd2));
    tbl.push_back(mk(0, OP_LW,   4'b0000, 3'd3, 5'b00000, 0, 2'b00, 4'd2));
    tbl.push_back(mk(0, OP_LW,   4'b0010, 3'd4, 5'b01000, 0, 2'b00, 4'd2));
    tbl.push_back(mk(0, OP_LW,   4'b0001, 3'd5, 5'b00011, 0, 2'b00, 4'd2));
    tbl.push_back(mk(0, OP_LW,   4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_LW,   4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd3, 5'b00000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd4, 5'b01000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd4, 5'b01000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd4, 5'b01000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0010, 3'd4, 5'b01000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd5, 5'b00000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0000, 3'd5, 5'b00000, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_SW,   4'b0001, 3'd5, 5'b00010, 0, 2'b00, 4'd3));
    tbl.push_back(mk(0, OP_BAD,  4'b1111, 3'd1, 5'b10000, 0, 2'b00, 4'd4));
    tbl.push_back(mk(0, OP_BAD,  4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd4));
    tbl.push_back(mk(0, OP_BAD,  4'b0000, 3'd3, 5'b00000, 0, 2'b00, 4'd4));
    tbl.push_back(mk(0, OP_BAD,  4'b1111, 3'd6, 5'b00000, 1, 2'b01, 4'd4));
    tbl.push_back(mk(0, OP_BAD,  4'b1111, 3'd6, 5'b00000, 1, 2'b01, 4'd4));

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // reset out of trap, then reset in the middle of MEM_WAIT
    run(mk(1, OP_ADDI, 4'b0000, 3'd6, 5'b00000, 1, 2'b01, 4'd4), "rst_trap");
    run(mk(0, OP_ADDI, 4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0), "rst_out");
    run(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd0), "mw_f1");
    run(mk(0, OP_ADDI, 4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd0), "mw_f2");
    run(mk(0, OP_ADDI, 4'b0000, 3'd3, 5'b00010, 0, 2'b00, 4'd0), "mw_d1");
    run(mk(0, OP_LW,   4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd1), "mw_f3");
    run(mk(0, OP_LW,   4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd1), "mw_f4");
    run(mk(0, OP_LW,   4'b0000, 3'd3, 5'b00000, 0, 2'b00, 4'd1), "mw_d2");
    run(mk(0, OP_LW,   4'b0010, 3'd4, 5'b01000, 0, 2'b00, 4'd1), "mw_mr");
    run(mk(1, OP_LW,   4'b0000, 3'd5, 5'b00000, 0, 2'b00, 4'd1), "mw_rst");
    run(mk(0, OP_LW,   4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0), "mw_post");

    // imem watchdog: four cycles in FETCH_REQ without ready
    for (int i = 0; i < 4; i++)
      run(mk(0, OP_ADDI, 4'b0000, 3'd1, 5'b10000, 0, 2'b00, 4'd0),
          $sformatf("wd_f%0d", i));
    run(mk(0, OP_ADDI, 4'b1111, 3'd6, 5'b00000, 1, 2'b10, 4'd0), "wd_trap");

    // ready on the expiry cycle wins; then FETCH_WAIT expires
    run(mk(1, OP_ADDI, 4'b0000, 3'd6, 5'b00000, 1, 2'b10, 4'd0), "wd_rst");
    run(mk(0, OP_ADDI, 4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0), "wd2_r");
    for (int i = 0; i < 3; i++)
      run(mk(0, OP_ADDI, 4'b0000, 3'd1, 5'b10000, 0, 2'b00, 4'd0),
          $sformatf("wd2_f%0d", i));
    run(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd0), "wd2_exp");
    for (int i = 0; i < 4; i++)
      run(mk(0, OP_ADDI, 4'b0000, 3'd2, 5'b00000, 0, 2'b00, 4'd0),
          $sformatf("wd2_w%0d", i));
    run(mk(0, OP_ADDI, 4'b0000, 3'd6, 5'b00000, 1, 2'b10, 4'd0), "wd2_trap");

    // dmem watchdog in MEM_WAIT
    run(mk(1, OP_ADDI, 4'b0000, 3'd6, 5'b00000, 1, 2'b10, 4'd0), "wd3_rst");
    run(mk(0, OP_LW,   4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0), "wd3_r");
    run(mk(0, OP_LW,   4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'd0), "wd3_f1");
    run(mk(0, OP_LW,   4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'd0), "wd3_f2");
    run(mk(0, OP_LW,   4'b0000, 3'd3, 5'b00000, 0, 2'b00, 4'd0), "wd3_d");
    run(mk(0, OP_LW,   4'b0010, 3'd4, 5'b01000, 0, 2'b00, 4'd0), "wd3_mr");
    for (int i = 0; i < 4; i++)
      run(mk(0, OP_LW, 4'b0000, 3'd5, 5'b00000, 0, 2'b00, 4'd0),
          $sformatf("wd3_w%0d", i));
    run(mk(0, OP_LW,   4'b0000, 3'd6, 5'b00000, 1, 2'b11, 4'd0), "wd3_trap");

    // 17 zero-wait ADDI on a 4-bit counter wraps to 1
    run(mk(1, OP_ADDI, 4'b0000, 3'd6, 5'b00000, 1, 2'b11, 4'd0), "wr_rst");
    run(mk(0, OP_ADDI, 4'b0000, 3'd0, 5'b00000, 0, 2'b00, 4'd0), "wr_r");
    for (int i = 0; i < 17; i++) begin
      run(mk(0, OP_ADDI, 4'b1000, 3'd1, 5'b10000, 0, 2'b00, 4'(i)),
          $sformatf("wr_a%0d", i));
      run(mk(0, OP_ADDI, 4'b0100, 3'd2, 5'b00100, 0, 2'b00, 4'(i)),
          $sformatf("wr_b%0d", i));
      run(mk(0, OP_ADDI, 4'b0000, 3'd3, 5'b00010, 0, 2'b00, 4'(i)),
          $sformatf("wr_c%0d", i));
    end
    run(mk(0, OP_ADDI, 4'b0000, 3'd1, 5'b10000, 0, 2'b00, 4'd1), "wr_end");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
